// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: mode encodings used by the
// register itself, the control unit and the ALU.
package universal_register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b111;

  // True for the two modes that consume serial_in.
  function automatic logic mode_uses_serial(input logic [MODE_W-1:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state logic: computes the next register value and
// carry/shift-out bit for every mode.
module universal_register_next
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_q,
  input  logic              i_carry,
  input  logic [WIDTH-1:0]  i_d,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_serial_in,
  output logic [WIDTH-1:0]  o_q_next,
  output logic              o_carry_next
);

  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_borrow;

  assign w_inc    = {1'b0, i_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec    = i_q - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_borrow = (i_q == '0);

  // Unknown or HOLD mode falls through to the default and keeps state.
  always_comb begin
    o_q_next     = i_q;
    o_carry_next = i_carry;
    case (i_mode)
      MODE_LOAD: begin
        o_q_next     = i_d;
        o_carry_next = 1'b0;
      end
      MODE_INC: begin
        o_q_next     = w_inc[WIDTH-1:0];
        o_carry_next = w_inc[WIDTH];
      end
      MODE_DEC: begin
        o_q_next     = w_dec;
        o_carry_next = w_borrow;
      end
      MODE_SHL: begin
        o_q_next     = {i_q[WIDTH-2:0], i_serial_in};
        o_carry_next = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q_next     = {i_serial_in, i_q[WIDTH-1:1]};
        o_carry_next = i_q[0];
      end
      MODE_ROL: begin
        o_q_next     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_carry_next = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q_next     = {i_q[0], i_q[WIDTH-1:1]};
        o_carry_next = i_q[0];
      end
      default: begin
        o_q_next     = i_q;
        o_carry_next = i_carry;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Parametrised multi-mode register with registered carry/shift-out and a
// combinational zero flag. Priority: clear, then clock_enable, then mode.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              clock_enable,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  q,
  output logic              carry_out,
  output logic              zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_q_next;
  logic             w_carry_next;

  universal_register_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q          (r_q),
    .i_carry      (r_carry),
    .i_d          (d),
    .i_mode       (mode),
    .i_serial_in  (serial_in),
    .o_q_next     (w_q_next),
    .o_carry_next (w_carry_next)
  );

  // The next-state value is only consumed when enabled and not clearing,
  // so an unknown mode in those cycles cannot reach the flops.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_q     <= RESET_VALUE;
      r_carry <= 1'b0;
    end else if (clock_enable) begin
      r_q     <= w_q_next;
      r_carry <= w_carry_next;
    end
  end

  assign q         = r_q;
  assign carry_out = r_carry;
  assign zero      = ~|r_q;

endmodule
